// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset fetch address, RV32 major
// opcode values seen on id_opcode, and the canonical NOP encoding.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle.
//   imem_req_*  : fetch request to instruction memory (valid/ready, addr)
//   imem_resp_* : in-order instruction response from memory
//   redirect_*  : flush/restart from later pipeline stages
//   id_*        : instruction, PC and opcode handed to decode (valid/ready)
// master = fetch unit side, slave = memory/pipeline environment side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count.
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous flush (same effect as rst)
//   push/din : write an entry (caller never pushes when full)
//   pop/dout : dout is the head (combinational); pop removes it
//   count    : current number of entries
// Simultaneous push and pop is allowed and leaves count unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  // Popping an empty FIFO is ignored so the count can never underflow.
  assign do_pop = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if master (imem request/response, redirect, decode)
// Holds the PC, issues word fetches under a credit limit so the instruction
// buffer can never overflow, buffers in-order responses and presents the head
// to decode. A redirect flushes the buffer and marks every in-flight request
// as stale so its response is dropped when it eventually returns.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     ibuf_count;
  logic [XLEN-1:0]   rq_head;
  logic [2*XLEN-1:0] ibuf_head;
  logic              req_fire;
  logic              ibuf_push;
  logic              id_fire;

  // Credit: in-flight requests plus buffered instructions never exceed the
  // buffer depth, so every returning response has a slot waiting for it.
  always_comb begin
    bus.imem_req_valid = !rst && !bus.redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, ibuf_count}) < DEPTH_W);
    bus.id_valid       = !rst && !bus.redirect_valid && (ibuf_count != '0);
  end

  assign bus.imem_req_addr = pc;
  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign id_fire   = bus.id_valid && bus.id_ready;
  // A response that lands during a redirect is wrong-path by definition.
  assign ibuf_push = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;

  assign bus.id_instr  = ibuf_head[2*XLEN-1:XLEN];
  assign bus.id_pc     = ibuf_head[XLEN-1:0];
  assign bus.id_opcode = ibuf_head[XLEN+6:XLEN];

  // The request-PC queue holds exactly the accepted-but-unanswered requests,
  // so its occupancy is the outstanding count. It is never flushed by a
  // redirect: stale responses still return and must pop their entries.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_req_pc_q (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (req_fire),
    .din   (pc),
    .pop   (bus.imem_resp_valid),
    .dout  (rq_head),
    .count (outstanding)
  );

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect_valid),
    .push  (ibuf_push),
    .din   ({bus.imem_resp_data, rq_head}),
    .pop   (id_fire),
    .dout  (ibuf_head),
    .count (ibuf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc & ~XLEN'(3);
      // Everything still in flight is stale; a response arriving right now
      // is already being discarded and leaves the in-flight set this cycle.
      drop_cnt <= outstanding - {{(CW - 1){1'b0}}, bus.imem_resp_valid};
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      if (bus.imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          buffered = 0;
  logic [31:0] mpc      = RESET_PC;
  logic [31:0] salt     = 32'h0;
  int          rdy_pct  = 100;
  int          idr_pct  = 100;
  int          resp_pct = 100;
  int          lat_min  = 1;
  int          lat_max  = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    if (a == 32'hFFFF_FFF8) return 32'h00A0_0093;
    return a ^ salt;
  endfunction

  // One clock of environment: drive inputs, check handshake-level behaviour
  // against an abstract model (in-flight set, epochs, buffered count).
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc);
    bit    resp_now;
    bit    exp_rv;
    bit    exp_idv;
    mreq_t m;
    @(negedge clk);
    rst                = r;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.id_ready       = ($urandom_range(99) < idr_pct);
    resp_now = !r && (mq.size() > 0) && (mq[0].due <= cyc) &&
               ($urandom_range(99) < resp_pct);
    bus.imem_resp_valid = resp_now;
    bus.imem_resp_data  = resp_now ? mq[0].data : $urandom;
    #1;
    exp_rv  = !r && !rd && ((mq.size() + buffered) < 2);
    exp_idv = !r && !rd && (buffered > 0);
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("id_valid", bus.id_valid, exp_idv);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, mpc);
      m.data  = data_fn(bus.imem_req_addr);
      m.due   = cyc + $urandom_range(lat_max, lat_min);
      m.epoch = epoch;
      mq.push_back(m);
      sb.push_back('{pc: mpc, instr: data_fn(mpc)});
      mpc = mpc + 32'd4;
    end
    if (bus.id_valid && bus.id_ready) buffered--;
    if (resp_now) begin
      m = mq.pop_front();
      if (m.epoch == epoch) buffered++;
    end
    if (r || rd) begin
      buffered = 0;
      epoch++;
      sb.delete();
      mpc = r ? RESET_PC : {rpc[31:2], 2'b00};
    end
    if (r) mq.delete();
    cyc++;
  endtask

  // Monitor: every decode handshake must deliver the next expected instruction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && bus.id_valid && bus.id_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL id_unexpected actual_pc=%0h expected=none (cycle %0d)", bus.id_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_instr", bus.id_instr, e.instr);
        chk("id_opcode", bus.id_opcode, e.instr[6:0]);
      end
    end
  end

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.id_ready        = 1'b0;

    // Reset, then always-ready 1-cycle memory returning addr as data.
    repeat (2) step(1, 0, 0);
    repeat (24) step(0, 0, 0);

    // Decode stalls; credit must cap in-flight + buffered at 2.
    idr_pct = 0;
    repeat (10) step(0, 0, 0);
    idr_pct = 100;
    repeat (10) step(0, 0, 0);

    // 3-cycle memory; redirect to 0x1003 with two requests outstanding.
    lat_min = 3; lat_max = 3;
    begin
      int i;
      for (i = 0; i < 50 && mq.size() != 2; i++) step(0, 0, 0);
      chk("setup_two_outstanding", mq.size(), 2);
    end
    step(0, 1, 32'h0000_1003);
    repeat (15) step(0, 0, 0);

    // Redirect in the same cycle a response is presented, id_ready high.
    begin
      int i;
      for (i = 0; i < 50 && !(mq.size() > 0 && mq[0].due <= cyc); i++) step(0, 0, 0);
      chk("setup_resp_due", (mq.size() > 0 && mq[0].due <= cyc), 1);
    end
    step(0, 1, 32'h0000_2000);
    repeat (15) step(0, 0, 0);

    // Wrap past the top of the address space; opcode field check.
    lat_min = 1; lat_max = 1;
    step(0, 1, 32'hFFFF_FFF8);
    repeat (12) step(0, 0, 0);

    // Reset with requests outstanding and the buffer filling.
    lat_min = 3; lat_max = 3;
    idr_pct = 0;
    repeat (8) step(0, 0, 0);
    step(1, 0, 0);
    idr_pct = 100;
    repeat (12) step(0, 0, 0);

    // Randomized traffic: backpressure, variable latency, redirects, resets.
    rdy_pct = 70; idr_pct = 70; resp_pct = 80;
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 2500; k++) begin
      if (k % 300 == 0) salt = $urandom;
      if ($urandom_range(999) < 5)
        step(1, 0, 0);
      else if ($urandom_range(99) < 3)
        step(0, 1, $urandom);
      else
        step(0, 0, 0);
    end

    rdy_pct = 100; idr_pct = 100; resp_pct = 100;
    repeat (30) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
